// File: rtl/div_operand_stage.sv
// -----------------------------------------------------------------------------
// div_operand_stage
//
// Registered wrapper around a combinational 16/8 restoring array divider.
// Operands arrive on a valid/ready handshake and are held in an operand
// register (S1) that drives the array. One cycle later the array result is
// captured in a result register (S2). S2 also carries divide-by-zero and
// quotient-overflow flags and is presented on a second valid/ready handshake.
//
// Optional feature, enabled by defining DIV_STAGE_STATS_EN:
//   three saturating 16-bit counters of delivered results, cleared by stats_clr.
//
// Parameters:
//   NW  dividend width (must be 2*DW)
//   DW  divisor / quotient / remainder width
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready     operand handshake
//   in_n, in_d            dividend, divisor
//   arr_n, arr_d          registered operands driven to the array
//   arr_q, arr_r          array quotient / remainder (combinational from arr_*)
//   out_valid/out_ready   result handshake
//   out_q, out_r          quotient, remainder
//   out_dz, out_ovf       divisor was zero, quotient does not fit in DW bits
//   stats_clr             (DIV_STAGE_STATS_EN) synchronous counter clear
//   stat_ops/dz/ovf       (DIV_STAGE_STATS_EN) delivered result counters
// -----------------------------------------------------------------------------
module div_operand_stage #(
    parameter int NW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NW-1:0] in_n,
    input  logic [DW-1:0] in_d,
    output logic [NW-1:0] arr_n,
    output logic [DW-1:0] arr_d,
    input  logic [DW-1:0] arr_q,
    input  logic [DW-1:0] arr_r,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_q,
    output logic [DW-1:0] out_r,
    output logic          out_dz,
    output logic          out_ovf
`ifdef DIV_STAGE_STATS_EN
    ,
    input  logic          stats_clr,
    output logic [15:0]   stat_ops,
    output logic [15:0]   stat_dz,
    output logic [15:0]   stat_ovf
`endif
);

    // S1: operand register
    logic          s1_valid_q, s1_valid_d;
    logic [NW-1:0] arr_n_q, arr_n_d;
    logic [DW-1:0] arr_d_q, arr_d_d;
    logic          s1_dz_q, s1_dz_d;
    logic          s1_ovf_q, s1_ovf_d;

    // S2: result register
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_q_q, out_q_d;
    logic [DW-1:0] out_r_q, out_r_d;
    logic          out_dz_q, out_dz_d;
    logic          out_ovf_q, out_ovf_d;

    logic s2_free;
    logic s1_adv;
    logic accept;
    logic in_dz;

    // NOTE: every signal assigned in always_comb gets a default before any
    // condition; a path that leaves one unassigned would infer a latch.
    always_comb begin
        s2_free  = ~out_valid_q | out_ready;
        s1_adv   = s1_valid_q & s2_free;
        // No skid buffer: S1 can take a new pair if empty or emptying now.
        in_ready = ~s1_valid_q | s2_free;
        accept   = in_valid & in_ready;
        in_dz    = (in_d == '0);

        // Idle S1 holds its operands so the array output never toggles.
        s1_valid_d = s1_valid_q;
        arr_n_d    = arr_n_q;
        arr_d_d    = arr_d_q;
        s1_dz_d    = s1_dz_q;
        s1_ovf_d   = s1_ovf_q;

        if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        // Accept after advance so a same-cycle refill keeps S1 full.
        if (accept) begin
            s1_valid_d = 1'b1;
            arr_n_d    = in_n;
            arr_d_d    = in_d;
            s1_dz_d    = in_dz;
            // Quotient fits in DW bits only if the upper dividend half < d.
            s1_ovf_d   = ~in_dz & (in_n[NW-1:DW] >= in_d);
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_q_d     = out_q_q;
        out_r_d     = out_r_q;
        out_dz_d    = out_dz_q;
        out_ovf_d   = out_ovf_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (s1_adv) begin
            out_valid_d = 1'b1;
            out_dz_d    = s1_dz_q;
            out_ovf_d   = s1_ovf_q;
            if (s1_dz_q) begin
                // The array result is meaningless for d == 0; report the
                // saturated quotient and the low dividend half as remainder.
                out_q_d = '1;
                out_r_d = arr_n_q[DW-1:0];
            end else if (s1_ovf_q) begin
                out_q_d = '1;
                out_r_d = arr_r;
            end else begin
                out_q_d = arr_q;
                out_r_d = arr_r;
            end
        end
    end

    // NOTE: the datapath registers are reset along with the valid bits so the
    // array sees defined operands and outputs read as zero straight after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            arr_n_q     <= '0;
            arr_d_q     <= '0;
            s1_dz_q     <= 1'b0;
            s1_ovf_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_q_q     <= '0;
            out_r_q     <= '0;
            out_dz_q    <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, whatever the statement order.
            s1_valid_q  <= s1_valid_d;
            arr_n_q     <= arr_n_d;
            arr_d_q     <= arr_d_d;
            s1_dz_q     <= s1_dz_d;
            s1_ovf_q    <= s1_ovf_d;
            out_valid_q <= out_valid_d;
            out_q_q     <= out_q_d;
            out_r_q     <= out_r_d;
            out_dz_q    <= out_dz_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign arr_n     = arr_n_q;
    assign arr_d     = arr_d_q;
    assign out_valid = out_valid_q;
    assign out_q     = out_q_q;
    assign out_r     = out_r_q;
    assign out_dz    = out_dz_q;
    assign out_ovf   = out_ovf_q;

`ifdef DIV_STAGE_STATS_EN
    logic [15:0] stat_ops_q, stat_ops_d;
    logic [15:0] stat_dz_q, stat_dz_d;
    logic [15:0] stat_ovf_q, stat_ovf_d;
    logic        out_fire;

    always_comb begin
        out_fire   = out_valid_q & out_ready;
        stat_ops_d = stat_ops_q;
        stat_dz_d  = stat_dz_q;
        stat_ovf_d = stat_ovf_q;

        // Clear takes priority over an increment in the same cycle.
        if (stats_clr) begin
            stat_ops_d = '0;
            stat_dz_d  = '0;
            stat_ovf_d = '0;
        end else if (out_fire) begin
            if (stat_ops_q != 16'hFFFF) stat_ops_d = stat_ops_q + 16'd1;
            if (out_dz_q && stat_dz_q != 16'hFFFF) stat_dz_d = stat_dz_q + 16'd1;
            if (out_ovf_q && stat_ovf_q != 16'hFFFF) stat_ovf_d = stat_ovf_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops_q <= '0;
            stat_dz_q  <= '0;
            stat_ovf_q <= '0;
        end else begin
            stat_ops_q <= stat_ops_d;
            stat_dz_q  <= stat_dz_d;
            stat_ovf_q <= stat_ovf_d;
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_dz  = stat_dz_q;
    assign stat_ovf = stat_ovf_q;
`endif

endmodule

// File: tb/tb_div_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_div_operand_stage
//
// Self-checking bench for div_operand_stage. An exact behavioural divider
// stands in for the array. Expected results are computed from the operands
// when an operand handshake occurs and queued. Delivered results are queued
// when a result handshake occurs, and each scenario task pops and compares
// them. Compile with +define+DIV_STAGE_STATS_EN to also exercise the counters.
// -----------------------------------------------------------------------------
module tb_div_operand_stage;

    localparam int NW = 16;
    localparam int DW = 8;

    typedef struct packed {
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          dz;
        logic          ovf;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] in_n;
    logic [DW-1:0] in_d;
    logic [NW-1:0] arr_n;
    logic [DW-1:0] arr_d;
    logic [DW-1:0] arr_q;
    logic [DW-1:0] arr_r;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_q;
    logic [DW-1:0] out_r;
    logic          out_dz;
    logic          out_ovf;
`ifdef DIV_STAGE_STATS_EN
    logic          stats_clr;
    logic [15:0]   stat_ops;
    logic [15:0]   stat_dz;
    logic [15:0]   stat_ovf;
`endif

    int   checks   = 0;
    int   failures = 0;
    res_t exp_q[$];
    res_t obs_q[$];
    logic last_acc;
    logic last_fire;
    logic last_in_ready;

    div_operand_stage #(.NW(NW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_n      (in_n),
        .in_d      (in_d),
        .arr_n     (arr_n),
        .arr_d     (arr_d),
        .arr_q     (arr_q),
        .arr_r     (arr_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_r     (out_r),
        .out_dz    (out_dz),
        .out_ovf   (out_ovf)
`ifdef DIV_STAGE_STATS_EN
        ,
        .stats_clr (stats_clr),
        .stat_ops  (stat_ops),
        .stat_dz   (stat_dz),
        .stat_ovf  (stat_ovf)
`endif
    );

    always #5 clk = ~clk;

    // Exact combinational array stand-in.
    always_comb begin
        arr_q = '0;
        arr_r = '0;
        if (arr_d != '0) begin
            arr_q = 8'(arr_n / {8'h00, arr_d});
            arr_r = 8'(arr_n % {8'h00, arr_d});
        end
    end

    function automatic res_t model(input logic [NW-1:0] n, input logic [DW-1:0] d);
        res_t e;
        logic [NW-1:0] d16;
        d16 = {8'h00, d};
        if (d == '0) begin
            e = '{q: 8'hFF, r: n[7:0], dz: 1'b1, ovf: 1'b0};
        end else if ((n / d16) > 16'd255) begin
            e = '{q: 8'hFF, r: 8'(n % d16), dz: 1'b0, ovf: 1'b1};
        end else begin
            e = '{q: 8'(n / d16), r: 8'(n % d16), dz: 1'b0, ovf: 1'b0};
        end
        return e;
    endfunction

    // Called at posedge+1 after inputs are driven; samples both handshakes
    // mid-cycle, records them in the queues, then advances one edge.
    task automatic tick();
        res_t o;
        #1;
        last_in_ready = in_ready;
        last_acc      = in_valid & in_ready;
        last_fire     = out_valid & out_ready;
        if (last_acc) exp_q.push_back(model(in_n, in_d));
        if (last_fire) begin
            o = '{q: out_q, r: out_r, dz: out_dz, ovf: out_ovf};
            obs_q.push_back(o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
        end
        checks++;
        if (arr_n !== 16'h0 || arr_d !== 8'h0) begin
            failures++;
            $display("FAIL reset_arr: arr_n=%h arr_d=%h, want 0/0", arr_n, arr_d);
        end
        checks++;
        if (out_q !== 8'h0 || out_r !== 8'h0 || out_dz !== 1'b0 || out_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: q=%h r=%h dz=%b ovf=%b, want all 0",
                     out_q, out_r, out_dz, out_ovf);
        end
    endtask

    // Single operations with hand-derived results; also checks latency and
    // that the operand register holds once idle.
    task automatic test_directed();
        logic [NW-1:0] vn [4] = '{16'd100, 16'h1234, 16'h0900, 16'h08FF};
        logic [DW-1:0] vd [4] = '{8'd7, 8'h00, 8'h09, 8'h09};
        res_t          ve [4] = '{'{8'd14, 8'd2, 1'b0, 1'b0},
                                  '{8'hFF, 8'h34, 1'b1, 1'b0},
                                  '{8'hFF, 8'h00, 1'b0, 1'b1},
                                  '{8'hFF, 8'h08, 1'b0, 1'b0}};
        res_t got;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_n     = vn[i];
            in_d     = vd[i];
            tick();
            in_valid = 1'b0;
            checks++;
            if (last_acc !== 1'b1) begin
                failures++;
                $display("FAIL directed%0d_accept: accepted=%b, want 1", i, last_acc);
            end
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL directed%0d_early: out_valid=%b one edge after accept, want 0",
                         i, out_valid);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1) begin
                failures++;
                $display("FAIL directed%0d_latency: out_valid=%b two edges after accept, want 1",
                         i, out_valid);
            end
            got = '{q: out_q, r: out_r, dz: out_dz, ovf: out_ovf};
            checks++;
            if (got !== ve[i]) begin
                failures++;
                $display("FAIL directed%0d_result: q=%h r=%h dz=%b ovf=%b, want q=%h r=%h dz=%b ovf=%b",
                         i, got.q, got.r, got.dz, got.ovf, ve[i].q, ve[i].r, ve[i].dz, ve[i].ovf);
            end
            tick();
            checks++;
            if (out_valid !== 1'b0 || arr_n !== vn[i] || arr_d !== vd[i]) begin
                failures++;
                $display("FAIL directed%0d_idle: out_valid=%b arr_n=%h arr_d=%h, want 0 %h %h",
                         i, out_valid, arr_n, arr_d, vn[i], vd[i]);
            end
            exp_q.delete();
            obs_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] fire_seen;
        res_t got, want;
        out_ready = 1'b1;
        fire_seen = '0;
        for (int t = 0; t < 8; t++) begin
            in_valid = (t < 4);
            in_n     = 16'($urandom);
            in_d     = 8'($urandom_range(0, 255));
            tick();
            fire_seen[t] = last_fire;
            if (t < 4) begin
                checks++;
                if (last_in_ready !== 1'b1 || last_acc !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_in_ready: cycle %0d in_ready=%b, want 1", t, last_in_ready);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (fire_seen !== 8'b0011_1100) begin
            failures++;
            $display("FAIL b2b_timing: result cycles=%b, want 00111100", fire_seen);
        end
        checks++;
        if (obs_q.size() != 4) begin
            failures++;
            $display("FAIL b2b_count: results=%0d, want 4", obs_q.size());
        end
        while (obs_q.size() != 0) begin
            got = obs_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL b2b_order: extra result q=%h r=%h", got.q, got.r);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL b2b_order: q=%h r=%h dz=%b ovf=%b, want q=%h r=%h dz=%b ovf=%b",
                             got.q, got.r, got.dz, got.ovf, want.q, want.r, want.dz, want.ovf);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [NW-1:0] ops_n [3];
        logic [DW-1:0] ops_d [3];
        logic [4:0]    rdy_seen;
        res_t          snap, cur, got, want;
        int            idx;
        for (int i = 0; i < 3; i++) begin
            ops_n[i] = 16'($urandom);
            ops_d[i] = 8'($urandom_range(1, 255));
        end
        out_ready = 1'b0;
        idx       = 0;
        rdy_seen  = '0;
        snap      = '0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 3);
            in_n     = ops_n[idx < 3 ? idx : 2];
            in_d     = ops_d[idx < 3 ? idx : 2];
            tick();
            rdy_seen[c] = last_in_ready;
            if (last_acc) idx++;
            cur = '{q: out_q, r: out_r, dz: out_dz, ovf: out_ovf};
            if (c == 2) snap = cur;
            if (c > 2) begin
                checks++;
                if (out_valid !== 1'b1 || cur !== snap) begin
                    failures++;
                    $display("FAIL bp_stable: cycle %0d valid=%b q=%h r=%h, want 1 q=%h r=%h",
                             c, out_valid, cur.q, cur.r, snap.q, snap.r);
                end
            end
        end
        checks++;
        if (idx != 2) begin
            failures++;
            $display("FAIL bp_accepted: accepted=%0d, want 2", idx);
        end
        checks++;
        if (rdy_seen !== 5'b00011) begin
            failures++;
            $display("FAIL bp_in_ready: in_ready by cycle=%b, want 00011", rdy_seen);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && obs_q.size() < 3; c++) begin
            in_valid = (idx < 3);
            in_n     = ops_n[idx < 3 ? idx : 2];
            in_d     = ops_d[idx < 3 ? idx : 2];
            tick();
            if (last_acc) idx++;
        end
        in_valid = 1'b0;
        repeat (2) tick();
        checks++;
        if (obs_q.size() != 3) begin
            failures++;
            $display("FAIL bp_count: results=%0d, want 3", obs_q.size());
        end
        while (obs_q.size() != 0) begin
            got = obs_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL bp_order: extra result q=%h r=%h", got.q, got.r);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL bp_order: q=%h r=%h dz=%b ovf=%b, want q=%h r=%h dz=%b ovf=%b",
                             got.q, got.r, got.dz, got.ovf, want.q, want.r, want.dz, want.ovf);
                end
            end
        end
        exp_q.delete();
    endtask

`ifdef DIV_STAGE_STATS_EN
    task automatic test_stats();
        logic [NW-1:0] sn [5] = '{16'd100, 16'h0050, 16'h00FF, 16'h1234, 16'h0900};
        logic [DW-1:0] sd [5] = '{8'd7, 8'd3, 8'd16, 8'h00, 8'h09};
        out_ready = 1'b1;
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        for (int t = 0; t < 9; t++) begin
            in_valid = (t < 5);
            in_n     = sn[t < 5 ? t : 4];
            in_d     = sd[t < 5 ? t : 4];
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (stat_ops !== 16'd5 || stat_dz !== 16'd1 || stat_ovf !== 16'd1) begin
            failures++;
            $display("FAIL stats_count: ops=%0d dz=%0d ovf=%0d, want 5 1 1",
                     stat_ops, stat_dz, stat_ovf);
        end
        in_valid = 1'b1;
        in_n     = 16'h0900;
        in_d     = 8'h09;
        tick();
        in_valid = 1'b0;
        tick();
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        checks++;
        if (last_fire !== 1'b1 || stat_ops !== 16'd0 || stat_dz !== 16'd0 || stat_ovf !== 16'd0) begin
            failures++;
            $display("FAIL stats_clr: handshake=%b ops=%0d dz=%0d ovf=%0d, want 1 0 0 0",
                     last_fire, stat_ops, stat_dz, stat_ovf);
        end
        // Leave nonzero counts behind so the mid-stream reset has work to do.
        in_valid = 1'b1;
        in_n     = 16'd50;
        in_d     = 8'd5;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        exp_q.delete();
        obs_q.delete();
    endtask
`endif

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            in_valid = 1'b1;
            in_n     = 16'($urandom);
            in_d     = 8'($urandom_range(1, 255));
            tick();
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_flush: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
        end
`ifdef DIV_STAGE_STATS_EN
        checks++;
        if (stat_ops !== 16'd0 || stat_dz !== 16'd0 || stat_ovf !== 16'd0) begin
            failures++;
            $display("FAIL midrst_stats: ops=%0d dz=%0d ovf=%0d, want 0 0 0",
                     stat_ops, stat_dz, stat_ovf);
        end
`endif
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        repeat (3) tick();
        checks++;
        if (obs_q.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_residue: results=%0d out_valid=%b, want 0/0",
                     obs_q.size(), out_valid);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_n      = '0;
        in_d      = '0;
        out_ready = 1'b1;
`ifdef DIV_STAGE_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
`ifdef DIV_STAGE_STATS_EN
        test_stats();
`endif
        test_reset_midstream();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
